// File: rtl/audio_spi_responder.sv
// audio_spi_responder: SPI responder for the codec control port.
// Decodes 16-bit {addr, rw, data} frames into a 128x8 register file and returns read data on oDOUT.
module audio_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       iCLK_50,
    input  logic       iRESET_n,
    input  logic       iCS_n,
    input  logic       iSCLK,
    input  logic       iDIN,
    output logic       oDOUT,
    output logic       oDOUT_OE,
    input  logic [6:0] iRD_ADDR,
    output logic [7:0] oRD_DATA,
    output logic       oWR_STB,
    output logic [6:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic       oFRAME_ERR
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    state_t r_state, w_state_next;
    logic [SYNC_STAGES:0]   r_cs_pipe, r_sclk_pipe;
    logic [SYNC_STAGES-1:0] r_din_pipe;
    logic [7:0] r_sr, r_osr, r_wr_data, r_rd_data;
    logic [4:0] r_cnt;
    logic [6:0] r_addr, r_wr_addr;
    logic       r_rw, r_dout, r_oe, r_wr_stb, r_frame_err;
    logic [7:0] r_mem [128];
    logic w_cs_fall, w_cs_rise, w_sclk_fall, w_sclk_rise, w_din;
    logic w_start, w_shift, w_latch, w_dout_shift, w_do_write, w_err;

    // The top pipe bit is the history flop; the one below it is the synchronized level.
    assign w_cs_fall   = r_cs_pipe[SYNC_STAGES] & ~r_cs_pipe[SYNC_STAGES-1];
    assign w_cs_rise   = ~r_cs_pipe[SYNC_STAGES] & r_cs_pipe[SYNC_STAGES-1];
    assign w_sclk_fall = r_sclk_pipe[SYNC_STAGES] & ~r_sclk_pipe[SYNC_STAGES-1];
    assign w_sclk_rise = ~r_sclk_pipe[SYNC_STAGES] & r_sclk_pipe[SYNC_STAGES-1];
    assign w_din       = r_din_pipe[SYNC_STAGES-1];

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            r_cs_pipe   <= '1;
            r_sclk_pipe <= '1;
            r_din_pipe  <= '0;
        end else begin
            r_cs_pipe   <= {r_cs_pipe[SYNC_STAGES-1:0], iCS_n};
            r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-1:0], iSCLK};
            r_din_pipe  <= {r_din_pipe[SYNC_STAGES-2:0], iDIN};
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) r_state <= S_IDLE;
        else r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) w_state_next = S_IDLE;
        else if (r_state == S_IDLE && w_cs_fall) w_state_next = S_SHIFT;
        else if (r_state == S_SHIFT && r_cnt == 5'd16) w_state_next = S_DONE;
    end

    always_comb begin
        w_start      = r_state == S_IDLE && w_cs_fall;
        w_shift      = r_state == S_SHIFT && w_sclk_fall && r_cnt < 5'd16;
        w_latch      = w_shift && r_cnt == 5'd7;
        w_dout_shift = r_state == S_SHIFT && w_sclk_rise && r_rw && r_cnt >= 5'd8 && r_cnt < 5'd16;
        w_do_write   = r_state == S_SHIFT && r_cnt == 5'd16 && !r_rw;
        w_err        = w_cs_rise && r_cnt != 5'd0 && r_cnt < 5'd16;
    end

    // Only the low byte of the frame is ever needed: address+rw at bit 8, data at bit 16.
    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_addr <= '0;
            r_rw   <= 1'b0;
            r_osr  <= '0;
            r_dout <= 1'b0;
            r_oe   <= 1'b0;
        end else begin
            if (w_start) begin
                r_sr  <= '0;
                r_cnt <= '0;
                r_rw  <= 1'b0;
            end else if (w_shift) begin
                r_sr  <= {r_sr[6:0], w_din};
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_latch) begin
                r_addr <= r_sr[6:0];
                r_rw   <= w_din;
            end
            if (w_latch && w_din) begin
                r_osr <= r_mem[r_sr[6:0]];
                r_oe  <= 1'b1;
            end else if (w_dout_shift) begin
                r_dout <= r_osr[7];
                r_osr  <= {r_osr[6:0], 1'b0};
            end
            if (w_cs_rise) begin
                r_dout <= 1'b0;
                r_oe   <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            for (int i = 0; i < 128; i++) r_mem[i] <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_stb    <= w_do_write;
            r_frame_err <= w_err;
            r_rd_data   <= r_mem[iRD_ADDR];
            if (w_do_write) begin
                r_mem[r_addr] <= r_sr;
                r_wr_addr     <= r_addr;
                r_wr_data     <= r_sr;
            end
        end
    end

    assign oDOUT      = r_dout;
    assign oDOUT_OE   = r_oe;
    assign oRD_DATA   = r_rd_data;
    assign oWR_STB    = r_wr_stb;
    assign oWR_ADDR   = r_wr_addr;
    assign oWR_DATA   = r_wr_data;
    assign oFRAME_ERR = r_frame_err;
endmodule

// File: tb/tb_audio_spi_responder.sv
// tb_audio_spi_responder: directed SPI frames; write strobes checked against a queue of expected writes.
module tb_audio_spi_responder;
    localparam int HALF = 50;
    logic       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sclk = 1'b1, din = 1'b0;
    logic [6:0] rd_addr = '0;
    logic       dout, dout_oe, wr_stb, frame_err;
    logic [7:0] rd_data, wr_data;
    logic [6:0] wr_addr;
    int tests = 0, fails = 0, err_pulses = 0, bad = 0, e0 = 0;
    logic [15:0] cap;
    logic [14:0] exp_q [$];
    logic [14:0] mon_exp;

    audio_spi_responder #(.SYNC_STAGES(2)) dut (
        .iCLK_50(clk), .iRESET_n(rst_n), .iCS_n(cs_n), .iSCLK(sclk), .iDIN(din),
        .oDOUT(dout), .oDOUT_OE(dout_oe), .iRD_ADDR(rd_addr), .oRD_DATA(rd_data),
        .oWR_STB(wr_stb), .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oFRAME_ERR(frame_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_err) err_pulses++;
        if (rst_n && wr_stb) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wr_stb: unexpected write addr %0h data %0h", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_addr, wr_data} !== mon_exp) begin
                    fails++;
                    $display("FAIL wr_stb: got addr %0h data %0h expected addr %0h data %0h",
                             wr_addr, wr_data, mon_exp[14:8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] w, input int nbits, input bit keep_low);
        cap = '0;
        bad = 0;
        cs_n = 1'b0;
        din = w[15];
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            cap = {cap[14:0], dout};
            if (dout_oe !== (w[8] && i >= 8 && i < 16)) bad++;
            wait_clk(HALF);
            sclk = 1'b1;
            din = (i < 15) ? w[14-i] : 1'b0;
            wait_clk(HALF);
        end
        if (!keep_low) begin
            cs_n = 1'b1;
            din = 1'b0;
            wait_clk(HALF);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        frame({a, 1'b0, d}, 16, 1'b0);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] exp);
        frame({a, 1'b1, 8'hFF}, 16, 1'b0);
        check("rd_capture", cap[7:0], exp);
        check("rd_oe_window", bad, 0);
        check("rd_oe_after", dout_oe, 1'b0);
    endtask

    task automatic host(input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        wait_clk(2);
        check("host_rd", rd_data, exp);
    endtask

    task automatic check_reset_outputs;
        check("rst_dout", dout, 1'b0);
        check("rst_oe", dout_oe, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, 7'h00);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
    endtask

    initial begin
        wait_clk(3);
        check_reset_outputs();
        rst_n = 1'b1;
        wait_clk(5);
        wr(7'h22, 8'h01);
        check("wr_addr_hold", wr_addr, 7'h22);
        check("wr_data_hold", wr_data, 8'h01);
        host(7'h22, 8'h01);
        rd(7'h22, 8'h01);
        wr(7'h23, 8'h00);
        rd(7'h23, 8'h00);
        wr(7'h7F, 8'hA5);
        rd(7'h7F, 8'hA5);
        host(7'h7F, 8'hA5);
        e0 = err_pulses;
        frame({7'h10, 1'b0, 8'h99}, 11, 1'b0);
        check("frame_err_pulse", err_pulses - e0, 1);
        host(7'h10, 8'h00);
        wr(7'h10, 8'h5A);
        host(7'h10, 8'h5A);
        check("no_err_full_frame", err_pulses - e0, 1);
        exp_q.push_back({7'h05, 8'h3C});
        frame({7'h05, 1'b0, 8'h3C}, 18, 1'b0);
        host(7'h05, 8'h3C);
        frame({7'h30, 1'b0, 8'h77}, 12, 1'b1);
        rst_n = 1'b0;
        wait_clk(2);
        check_reset_outputs();
        cs_n = 1'b1;
        sclk = 1'b1;
        din = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        host(7'h30, 8'h00);
        host(7'h22, 8'h00);
        wr(7'h30, 8'h77);
        host(7'h30, 8'h77);
        wait_clk(10);
        check("queue_drained", exp_q.size(), 0);
        check("total_frame_errs", err_pulses, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
